io_tx_uart: RTL

IO_TX_UART -- requirements
Module: io_tx_uart

---
 rtl/io_tx_uart.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/io_tx_uart.sv
// io_tx_uart: byte-wide transmit UART (8N1) with a small byte FIFO in front.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   rst      - asynchronous, active-high reset (aborts any frame, empties FIFO)
//   in_data  - byte from the CPU OUT instruction
//   in_vld   - in_data is valid
//   in_rdy   - block can accept a byte this cycle (FIFO not full)
//   txd      - registered serial output, idle high, LSB first
//   busy     - FIFO non-empty or a frame in flight
//   err      - sticky error flags; err[0] = in_vld protocol violation
//
// Parameters:
//   CLK_PER_BIT - clock cycles per serial bit (2..65535)
//   DEPTH_LOG2  - log2 of the FIFO depth
module io_tx_uart #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned DEPTH_LOG2  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_vld,
    output logic       in_rdy,
    output logic       txd,
    output logic       busy,
    output logic [4:0] err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push;
    logic                  pop;

    // transmitter
    state_t      state, state_d;
    logic [15:0] baud_cnt, baud_d;
    logic [2:0]  bit_cnt, bit_d;
    logic [7:0]  shift, shift_d;
    logic        txd_d;
    logic        bit_end;

    // protocol checker
    logic       prev_blocked;
    logic [7:0] prev_data;
    logic       err_proto;

    // count only reaches DEPTH when full, so its MSB is the full flag.
    // rst is folded in so in_rdy reads 0 throughout reset.
    assign in_rdy  = !rst && !count[DEPTH_LOG2];
    assign push    = in_vld && in_rdy;
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign err     = {4'b0000, err_proto};

    // Storage has no reset; emptiness is carried by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            txd          <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            prev_blocked <= 1'b0;
            prev_data    <= '0;
            err_proto    <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            txd      <= txd_d;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            prev_blocked <= in_vld && !in_rdy;
            prev_data    <= in_data;
            if (prev_blocked && (!in_vld || (in_data != prev_data))) begin
                err_proto <= 1'b1;
            end
        end
    end

    // Next-state logic; a pop loads the head byte and restarts the counters
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_cnt + 3'd1;
                        shift_d = {1'b0, shift[7:1]};
                    end
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; txd is decoded from the next state so the flop
    // holds the level for the state being entered.
    always_comb begin
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign busy = (count != '0) || (state != IDLE);

endmodule
